// File: rtl/nios_system_switch_pkg.sv
// Shared constants for the switch PIO input conditioners.
package nios_system_switch_pkg;

  localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
  localparam logic [1:0] ST_WAIT_HIGH   = 2'd1;
  localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
  localparam logic [1:0] ST_WAIT_LOW    = 2'd3;

  typedef enum logic [1:0] {
    STABLE_LOW  = ST_STABLE_LOW,
    WAIT_HIGH   = ST_WAIT_HIGH,
    STABLE_HIGH = ST_STABLE_HIGH,
    WAIT_LOW    = ST_WAIT_LOW
  } state_e;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/nios_system_sync_ff.sv
// Plain flop chain that brings an asynchronous pin into the clk domain.
module nios_system_sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_d;
  logic [SYNC_STAGES-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_system_switch_debounce.sv
// Switch/pushbutton debouncer feeding the PIO in_port, with edge strobes
// and a wrapping press counter for debug.
module nios_system_switch_debounce
  import nios_system_switch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 20,
  parameter int unsigned PRESS_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   switch_raw,
  output logic                   switch_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [PRESS_WIDTH-1:0] press_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                   sync_q;
  state_e                 state_d,  state_q;
  logic [CNT_WIDTH-1:0]   cnt_d,    cnt_q;
  logic                   switch_d, switch_q;
  logic                   rise_d,   rise_q;
  logic                   fall_d,   fall_q;
  logic [PRESS_WIDTH-1:0] press_d,  press_q;

  nios_system_sync_ff #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (switch_raw),
    .q_out (sync_q)
  );

  // Hold-time qualification: a new level must be seen DEBOUNCE_CYCLES+1 edges running.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    switch_d = switch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    press_d  = press_q;
    unique case (state_q)
      STABLE_LOW: begin
        cnt_d = '0;
        if (sync_q) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HIGH;
          cnt_d    = '0;
          switch_d = 1'b1;
          rise_d   = 1'b1;
          press_d  = press_q + PRESS_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      STABLE_HIGH: begin
        cnt_d = '0;
        if (!sync_q) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LOW;
          cnt_d    = '0;
          switch_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      switch_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      press_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      switch_q <= switch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      press_q  <= press_d;
    end
  end

  assign switch_out  = switch_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign press_count = press_q;

endmodule

// File: tb/tb_nios_system_switch_debounce.sv
// Bench for nios_system_switch_debounce: a default-ish instance (2 stages, 4 cycles)
// and a swept instance (3 stages, 1 cycle) share one raw input stream.
module tb_nios_system_switch_debounce;

  localparam int unsigned S_A = 2;
  localparam int unsigned D_A = 4;
  localparam int unsigned S_B = 3;
  localparam int unsigned D_B = 1;

  typedef struct packed {
    logic       sw;
    logic       rise;
    logic       fall;
    logic [7:0] press;
  } exp_t;

  typedef struct {
    logic        raw;
    int unsigned hold;
    logic        exp_sw;
    logic [7:0]  exp_press;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       switch_raw = 1'b0;
  logic       sw_a, rise_a, fall_a;
  logic [7:0] press_a;
  logic       sw_b, rise_b, fall_b;
  logic [7:0] press_b;

  int checks = 0;
  int errors = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // Run-length reference: output flips once D+1 consecutive delayed samples differ.
  logic        m_pipe [2][4];
  int unsigned m_run  [2];
  logic        m_out  [2];
  logic [7:0]  m_press[2];
  int unsigned m_s    [2];
  int unsigned m_d    [2];

  vec_t vecs[10];

  always #5 clk = ~clk;

  nios_system_switch_debounce #(
    .SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A), .CNT_WIDTH(20), .PRESS_WIDTH(8)
  ) dut_a (
    .clk(clk), .reset(reset), .switch_raw(switch_raw),
    .switch_out(sw_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .press_count(press_a)
  );

  nios_system_switch_debounce #(
    .SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B), .CNT_WIDTH(4), .PRESS_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(reset), .switch_raw(switch_raw),
    .switch_out(sw_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .press_count(press_b)
  );

  task automatic model_step(input int i, input logic raw, input logic rst, output exp_t e);
    logic seen;
    e = '0;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_pipe[i][k] = 1'b0;
      m_run[i]   = 0;
      m_out[i]   = 1'b0;
      m_press[i] = 8'd0;
    end else begin
      seen = m_pipe[i][m_s[i]-1];
      for (int k = 3; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
      m_pipe[i][0] = raw;
      if (seen != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] == m_d[i] + 1) begin
          m_out[i] = seen;
          m_run[i] = 0;
          if (seen) begin
            e.rise = 1'b1;
            m_press[i] = m_press[i] + 8'd1;
          end else begin
            e.fall = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    e.sw    = m_out[i];
    e.press = m_press[i];
  endtask

  task automatic check_sb();
    exp_t ea, eb, aa, ab;
    aa = {sw_a, rise_a, fall_a, press_a};
    ab = {sw_b, rise_b, fall_b, press_b};
    if (sb_a.size() == 0 || sb_b.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      checks++;
      if (aa !== ea) begin
        errors++;
        $display("FAIL model_a t=%0t got sw=%b r=%b f=%b cnt=%0h expected sw=%b r=%b f=%b cnt=%0h",
                 $time, aa.sw, aa.rise, aa.fall, aa.press, ea.sw, ea.rise, ea.fall, ea.press);
      end
      checks++;
      assert (ab === eb) else begin
        errors++;
        $display("FAIL model_b t=%0t got sw=%b r=%b f=%b cnt=%0h expected sw=%b r=%b f=%b cnt=%0h",
                 $time, ab.sw, ab.rise, ab.fall, ab.press, eb.sw, eb.rise, eb.fall, eb.press);
      end
    end
  endtask

  // One clock: drive on the falling edge, predict, then compare just after the rising edge.
  task automatic tick(input logic raw, input logic rst);
    exp_t ea, eb;
    @(negedge clk);
    switch_raw = raw;
    reset      = rst;
    model_step(0, raw, rst, ea);
    model_step(1, raw, rst, eb);
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic lvl;
    m_s[0] = S_A; m_d[0] = D_A;
    m_s[1] = S_B; m_d[1] = D_B;

    vecs[0] = '{1'b1, 3,  1'b0, 8'd0};
    vecs[1] = '{1'b0, 2,  1'b0, 8'd0};
    vecs[2] = '{1'b1, 7,  1'b1, 8'd1};
    vecs[3] = '{1'b0, 6,  1'b1, 8'd1};
    vecs[4] = '{1'b0, 1,  1'b0, 8'd1};
    vecs[5] = '{1'b1, 10, 1'b1, 8'd2};
    vecs[6] = '{1'b0, 4,  1'b1, 8'd2};
    vecs[7] = '{1'b1, 4,  1'b1, 8'd2};
    vecs[8] = '{1'b0, 7,  1'b0, 8'd2};
    vecs[9] = '{1'b1, 7,  1'b1, 8'd3};

    // Reset release with raw high
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("reset_sw", 32'(sw_a), 32'd0);
    chk("reset_press", 32'(press_a), 32'd0);
    chk("reset_sw_b", 32'(sw_b), 32'd0);
    for (int e = 0; e < 9; e++) begin
      tick(1'b1, 1'b0);
      chk("rel_sw", 32'(sw_a), 32'(e >= 6));
      chk("rel_rise", 32'(rise_a), 32'(e == 6));
      chk("sweep_sw_b", 32'(sw_b), 32'(e >= 4));
      chk("sweep_rise_b", 32'(rise_b), 32'(e == 4));
    end
    chk("rel_press", 32'(press_a), 32'd1);

    // Bounce rejection
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    repeat (3) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int e = 0; e < 10; e++) begin
      tick(1'b1, 1'b0);
      chk("bounce_sw", 32'(sw_a), 32'(e >= 6));
    end
    chk("bounce_press", 32'(press_a), 32'd1);

    // Release from STABLE_HIGH
    for (int e = 0; e < 10; e++) begin
      tick(1'b0, 1'b0);
      chk("fall_sw", 32'(sw_a), 32'(e < 6));
      chk("fall_pulse", 32'(fall_a), 32'(e == 6));
      chk("fall_norise", 32'(rise_a), 32'd0);
    end
    chk("fall_press", 32'(press_a), 32'd1);

    // Reset in the middle of qualification
    repeat (4) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("midrst_sw", 32'(sw_a), 32'd0);
    chk("midrst_press", 32'(press_a), 32'd0);
    for (int e = 0; e < 8; e++) begin
      tick(1'b1, 1'b0);
      chk("midrst_rise_sw", 32'(sw_a), 32'(e >= 6));
    end
    chk("midrst_press_after", 32'(press_a), 32'd1);

    // Table of held segments from a fresh reset
    tick(1'b0, 1'b1);
    for (int v = 0; v < 10; v++) begin
      repeat (vecs[v].hold) tick(vecs[v].raw, 1'b0);
      chk($sformatf("vec%0d_sw", v), 32'(sw_a), 32'(vecs[v].exp_sw));
      chk($sformatf("vec%0d_press", v), 32'(press_a), 32'(vecs[v].exp_press));
    end

    // Press counter wrap
    tick(1'b0, 1'b1);
    for (int p = 1; p <= 256; p++) begin
      repeat (8) tick(1'b1, 1'b0);
      repeat (8) tick(1'b0, 1'b0);
      if (p == 255) chk("wrap_255", 32'(press_a), 32'h0000_00ff);
      if (p == 256) chk("wrap_256", 32'(press_a), 32'h0000_0000);
    end

    // Random bounce bursts followed by a settled level
    lvl = 1'b0;
    for (int p = 0; p < 50; p++) begin
      int unsigned nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < int'(nb); b++) begin
        repeat ($urandom_range(1, 3)) tick(~lvl, 1'b0);
        repeat ($urandom_range(1, 2)) tick(lvl, 1'b0);
      end
      lvl = ~lvl;
      repeat (10) tick(lvl, 1'b0);
      chk("rand_settled_a", 32'(sw_a), 32'(lvl));
      chk("rand_settled_b", 32'(sw_b), 32'(lvl));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
